// File: rtl/port_scan_sequencer_pkg.sv
// Shared constants and FSM encoding for the port scan sequencer.
//   NUM_PORTS / PORT_W / SEL_W : scan geometry (8 ports of 3 bits, 3-bit select)
//   CNT_W                      : settle counter width (SETTLE_CYCLES up to 15)
//   ST_*                       : 2-bit state codes used by state_e
package port_scan_sequencer_pkg;

  localparam int NUM_PORTS         = 8;
  localparam int PORT_W            = 3;
  localparam int SEL_W             = 3;
  localparam int CNT_W             = 4;
  localparam int SETTLE_CYCLES_DEF = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_EMIT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_SAMPLE = ST_SAMPLE,
    S_EMIT   = ST_EMIT
  } state_e;

endpackage

// File: rtl/port_scan_sequencer_if.sv
// Bus between the scan sequencer, the upstream port mux and the game-logic
// event consumer.
//   enable     : scan enable (level)
//   port_data  : value returned by the mux for the current select
//   select     : mux select / index of the port being scanned
//   snapshot   : last sampled value of every port, port i at [3i+2:3i]
//   evt_*      : valid/ready change event (port index + new value)
//   scan_done  : one-cycle pulse when port 7 retires
// slave = the sequencer, master = the environment driving it.
interface port_scan_sequencer_if;
  import port_scan_sequencer_pkg::*;

  logic                           enable;
  logic [PORT_W-1:0]              port_data;
  logic [SEL_W-1:0]               select;
  logic [NUM_PORTS*PORT_W-1:0]    snapshot;
  logic                           evt_valid;
  logic                           evt_ready;
  logic [SEL_W-1:0]               evt_port;
  logic [PORT_W-1:0]              evt_value;
  logic                           scan_done;

  modport slave (
    input  enable, port_data, evt_ready,
    output select, snapshot, evt_valid, evt_port, evt_value, scan_done
  );

  modport master (
    output enable, port_data, evt_ready,
    input  select, snapshot, evt_valid, evt_port, evt_value, scan_done
  );

endinterface

// File: rtl/port_snapshot_bank.sv
// Register file holding the last sampled value of each scanned port.
//   clock, reset_n : clock / async active-low reset (all entries clear to 0)
//   we_i           : write strobe
//   widx_i         : write index, also the index of the old-value read
//   wdata_i        : write data
//   old_o          : current (pre-write) contents of entry widx_i
//   snapshot_o     : all entries flattened, entry i at [3i+2:3i]
module port_snapshot_bank
  import port_scan_sequencer_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        we_i,
  input  logic [SEL_W-1:0]            widx_i,
  input  logic [PORT_W-1:0]           wdata_i,
  output logic [PORT_W-1:0]           old_o,
  output logic [NUM_PORTS*PORT_W-1:0] snapshot_o
);

  logic [NUM_PORTS-1:0][PORT_W-1:0] mem_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign old_o      = mem_q[widx_i];
  assign snapshot_o = mem_q;

endmodule

// File: rtl/port_scan_sequencer.sv
// Round-robin scanner in front of the 8:1 port-extractor mux. Holds each
// select for SETTLE_CYCLES, samples the mux output into the snapshot bank and
// raises a valid/ready event whenever a port's value differs from its last
// sample. scan_done pulses as port 7 retires.
//   clock, reset_n : clock / async active-low reset
//   bus            : slave side of port_scan_sequencer_if
//   SETTLE_CYCLES  : select hold time before sampling, legal 1..15
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | scan paused, select holds; enable starts a settle
// SETTLE | select stable, counting SETTLE_CYCLES cycles
// SAMPLE | one cycle: write bank, compare with old value
// EMIT   | event pending, wait for evt_ready before moving on
module port_scan_sequencer
  import port_scan_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  port_scan_sequencer_if.slave   bus
);

  // The counter starts at 0 on entry, so the last settle cycle is SETTLE_CYCLES-1.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_PORT   = SEL_W'(NUM_PORTS - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  evt_port_q, evt_port_d;
  logic [PORT_W-1:0] evt_value_q, evt_value_d;
  logic              advance;
  logic              snap_we;
  logic [PORT_W-1:0] old_val;
  logic [NUM_PORTS*PORT_W-1:0] snap_flat;

  port_snapshot_bank u_bank (
    .clock      (clock),
    .reset_n    (reset_n),
    .we_i       (snap_we),
    .widx_i     (sel_q),
    .wdata_i    (bus.port_data),
    .old_o      (old_val),
    .snapshot_o (snap_flat)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      evt_port_q  <= '0;
      evt_value_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      evt_port_q  <= evt_port_d;
      evt_value_q <= evt_value_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    evt_port_d  = evt_port_q;
    evt_value_d = evt_value_q;
    advance     = 1'b0;
    snap_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        // The bank is refreshed every visit; only a difference raises an event.
        snap_we = 1'b1;
        if (bus.port_data != old_val) begin
          evt_port_d  = sel_q;
          evt_value_d = bus.port_data;
          state_d     = S_EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_EMIT: begin
        if (bus.evt_ready) begin
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Retiring the current port is the only place select moves, so a dropped
    // enable always lets the port in flight finish first.
    if (advance) begin
      sel_d   = sel_q + 1'b1;
      cnt_d   = '0;
      state_d = bus.enable ? S_SETTLE : S_IDLE;
    end
  end

  assign bus.select    = sel_q;
  assign bus.snapshot  = snap_flat;
  assign bus.evt_valid = (state_q == S_EMIT);
  assign bus.evt_port  = evt_port_q;
  assign bus.evt_value = evt_value_q;
  assign bus.scan_done = advance && (sel_q == LAST_PORT);

endmodule

// File: tb/tb_port_scan_sequencer.sv
module tb_port_scan_sequencer;
  import port_scan_sequencer_pkg::*;

  localparam int TB_SETTLE = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic rst1_n  = 1'b0;
  always #5 clock = ~clock;

  port_scan_sequencer_if bus();
  port_scan_sequencer_if bus1();

  port_scan_sequencer #(.SETTLE_CYCLES(TB_SETTLE)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));
  port_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(rst1_n), .bus(bus1));

  // Port values presented by the modelled 8:1 mux.
  logic [2:0] pv [8];
  assign bus.port_data  = pv[bus.select];
  assign bus1.port_data = 3'd0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Walks the scan procedurally: per port, SETTLE cycles, one sample cycle,
  // then optionally an event that lasts until ready is seen at an edge.
  logic [2:0] e_sel, e_port, e_value;
  logic [2:0] e_snap [8];
  bit m_sampling, m_emitting, aborted;

  task automatic model_clear();
    e_sel = 0; e_port = 0; e_value = 0;
    for (int i = 0; i < 8; i++) e_snap[i] = 0;
    m_sampling = 0; m_emitting = 0;
  endtask

  task automatic tick();
    @(posedge clock or negedge reset_n);
    if (!reset_n) aborted = 1;
  endtask

  task automatic model_scan();
    logic [2:0] v;
    forever begin
      m_sampling = 0; m_emitting = 0;
      forever begin
        tick(); if (aborted) return;
        if (bus.enable) break;
      end
      forever begin
        repeat (TB_SETTLE) begin
          tick(); if (aborted) return;
        end
        m_sampling = 1;
        tick(); if (aborted) return;
        m_sampling = 0;
        v = pv[e_sel];
        if (v != e_snap[e_sel]) begin
          e_snap[e_sel] = v;
          e_port = e_sel;
          e_value = v;
          m_emitting = 1;
          forever begin
            tick(); if (aborted) return;
            if (bus.evt_ready) break;
          end
          m_emitting = 0;
        end
        e_sel = e_sel + 3'd1;
        if (!bus.enable) break;
      end
    end
  endtask

  initial begin
    forever begin
      model_clear();
      wait (reset_n === 1'b1);
      aborted = 0;
      model_scan();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin : cmp
    logic [23:0] flat;
    logic exp_done;
    for (int i = 0; i < 8; i++) flat[3*i +: 3] = e_snap[i];
    exp_done = (e_sel == 3'd7) &&
               ((m_sampling && (pv[7] == e_snap[7])) || (m_emitting && bus.evt_ready));
    chk("cmp_select", bus.select, e_sel);
    chk("cmp_evt_valid", bus.evt_valid, m_emitting);
    chk("cmp_evt_port", bus.evt_port, e_port);
    chk("cmp_evt_value", bus.evt_value, e_value);
    chk("cmp_scan_done", bus.scan_done, exp_done);
    chk("cmp_snapshot", bus.snapshot, flat);
  end

  task automatic wait_evt(input int max_cyc, output bit seen);
    seen = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clock);
      if (bus.evt_valid) begin
        seen = 1;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit seen;
    int first_done, nev;
    logic [2:0] sel12, sel24;
    logic [2:0] evp [4];
    int d_cyc [3];
    int nd, nev1;
    logic [2:0] s3;

    for (int i = 0; i < 8; i++) pv[i] = 3'd0;
    bus.enable = 0; bus.evt_ready = 1;
    bus1.enable = 0; bus1.evt_ready = 0;

    repeat (3) @(posedge clock); #1;
    chk("rst_select", bus.select, 0);
    chk("rst_snapshot", bus.snapshot, 0);
    chk("rst_evt_valid", bus.evt_valid, 0);
    chk("rst_scan_done", bus.scan_done, 0);
    reset_n = 1;

    // Quiet sweep: 3 cycles per port, scan_done in cycle 24.
    @(posedge clock); #1; bus.enable = 1;
    @(posedge clock);
    first_done = 0; nev = 0; sel12 = 0; sel24 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (bus.scan_done && first_done == 0) first_done = k;
      if (bus.evt_valid) nev++;
      if (k == 12) sel12 = bus.select;
      if (k == 24) sel24 = bus.select;
    end
    chk("quiet_done_cycle", first_done, 24);
    chk("quiet_events", nev, 0);
    chk("quiet_sel_k12", sel12, 3);
    chk("quiet_sel_k24", sel24, 7);
    chk("quiet_snapshot", bus.snapshot, 0);

    // Port 5 changes to 6, consumer always ready.
    @(posedge clock); #1; pv[5] = 3'd6;
    wait_evt(60, seen);
    chk("p5_evt_seen", seen, 1);
    chk("p5_evt_port", bus.evt_port, 5);
    chk("p5_evt_value", bus.evt_value, 6);
    @(negedge clock);
    chk("p5_valid_one_cycle", bus.evt_valid, 0);
    chk("p5_snapshot", bus.snapshot[17:15], 6);
    nev = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (bus.evt_valid) nev++;
    end
    chk("p5_no_repeat", nev, 0);

    // Backpressure on the port 2 event.
    @(posedge clock); #1; bus.evt_ready = 0; pv[2] = 3'd5;
    wait_evt(60, seen);
    chk("p2_evt_seen", seen, 1);
    chk("p2_evt_port", bus.evt_port, 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("p2_hold_select", bus.select, 2);
      chk("p2_hold_valid", bus.evt_valid, 1);
      chk("p2_hold_value", bus.evt_value, 5);
    end
    @(posedge clock); #1; bus.evt_ready = 1;
    @(posedge clock);
    @(negedge clock);
    chk("p2_release_select", bus.select, 3);
    chk("p2_release_valid", bus.evt_valid, 0);

    // Drop enable while port 4 settles; port 4 still completes.
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.select == 3'd4) begin
        seen = 1;
        break;
      end
    end
    chk("p4_reached", seen, 1);
    @(posedge clock); #1; bus.enable = 0; pv[4] = 3'd2;
    repeat (6) @(negedge clock);
    chk("dis_select", bus.select, 5);
    chk("dis_snap4", bus.snapshot[14:12], 2);
    chk("dis_valid", bus.evt_valid, 0);
    repeat (5) @(negedge clock);
    chk("dis_idle_select", bus.select, 5);
    @(posedge clock); #1; bus.enable = 1;
    @(posedge clock);
    repeat (3) @(negedge clock);
    chk("resume_k3_select", bus.select, 5);
    @(negedge clock);
    chk("resume_k4_select", bus.select, 6);

    // Reset in the middle of a pending port 6 event.
    @(posedge clock); #1; bus.evt_ready = 0; pv[6] = 3'd7;
    wait_evt(60, seen);
    chk("p6_evt_seen", seen, 1);
    chk("p6_evt_port", bus.evt_port, 6);
    @(posedge clock); #2; reset_n = 0;
    #1;
    chk("rstmid_valid", bus.evt_valid, 0);
    chk("rstmid_select", bus.select, 0);
    chk("rstmid_snapshot", bus.snapshot, 0);
    repeat (2) @(posedge clock); #1;
    reset_n = 1; bus.evt_ready = 1;
    nev = 0;
    for (int i = 0; i < 4; i++) evp[i] = 3'd0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clock);
      if (bus.evt_valid) begin
        if (nev < 4) evp[nev] = bus.evt_port;
        nev++;
      end
    end
    chk("rerun_events", nev, 4);
    chk("rerun_evt0", evp[0], 2);
    chk("rerun_evt1", evp[1], 4);
    chk("rerun_evt2", evp[2], 5);
    chk("rerun_evt3", evp[3], 6);
    chk("rerun_snapshot", bus.snapshot, 24'o07620500);

    // SETTLE_CYCLES=1 instance: 2 cycles per port, 16-cycle sweeps.
    @(posedge clock); #1; rst1_n = 1; bus1.enable = 1;
    @(posedge clock);
    nd = 0; nev1 = 0; s3 = 0;
    for (int i = 0; i < 3; i++) d_cyc[i] = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (bus1.scan_done) begin
        if (nd < 3) d_cyc[nd] = k;
        nd++;
      end
      if (bus1.evt_valid) nev1++;
      if (k == 3) s3 = bus1.select;
    end
    chk("s1_done0", d_cyc[0], 16);
    chk("s1_done1", d_cyc[1], 32);
    chk("s1_done2", d_cyc[2], 48);
    chk("s1_sel_k3", s3, 1);
    chk("s1_events", nev1, 0);
    chk("s1_snapshot", bus1.snapshot, 0);
    chk("s1_evt_port", bus1.evt_port, 0);
    chk("s1_evt_value", bus1.evt_value, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
